axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- AXI4-Lite initiator: converts single-beat commands from a local request/response port into AW/W/B or AR/R channel transactions.
- Drives the same channel signal set our axi_master_slave responder accepts; it replaces bench-driven stimulus in integrated systems.
- One outstanding transaction at a time; no bursts, no IDs.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, AWADDR, ARADDR
- DATA_WIDTH, 32, width of cmd_wdata, WDATA, RDATA, rsp_rdata

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP as returned
- AWADDR  out  ADDR_WIDTH; AWVALID out 1; AWREADY in 1
- WDATA  out  DATA_WIDTH; WVALID out 1; WREADY in 1
- BRESP  in  2; BVALID in 1; BREADY out 1
- ARADDR  out  ADDR_WIDTH; ARVALID out 1; ARREADY in 1
- RDATA  in  DATA_WIDTH; RRESP in 2; RVALID in 1; RREADY out 1

Behaviour:
- Reset, ARESET high at a rising edge:
  - State goes to IDLE.
  - All VALID/READY outputs, rsp_valid, rsp_write, rsp_resp, rsp_rdata, AWADDR, WDATA and ARADDR go to 0.
  - cmd_ready is 1 once out of reset.
- Reset mid-transaction: the transaction is abandoned and no response is produced.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, WR (AW/W phase), WR_B, RD_A, RD_R, RSP.
- IDLE:
  - cmd_valid && cmd_ready captures cmd_addr, cmd_wdata and cmd_write (edge 0).
  - Write: next state WR, with AWVALID=WVALID=1 from cycle 1. AWADDR and WDATA are held stable.
  - Read: next state RD_A, with ARVALID=1 from cycle 1.
- WR:
  - AW and W channels complete independently; flags aw_done and w_done are set.
  - AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops the cycle after WVALID&&WREADY.
  - Both handshakes may occur on the same edge.
  - When both are done, go to WR_B with BREADY=1.
  - VALID never drops before its handshake.
- WR_B: on BVALID&&BREADY, latch BRESP into rsp_resp, BREADY=0, go to RSP.
- RD_A: on ARVALID&&ARREADY, ARVALID=0, RREADY=1, go to RD_R.
- RD_R: on RVALID&&RREADY, latch RDATA and RRESP, RREADY=0, go to RSP.
- RSP:
  - rsp_valid=1; outputs are held stable until rsp_ready.
  - On handshake, rsp_valid=0 and state goes to IDLE; cmd_ready rises the next cycle.
- Minimum latency with slave ready and responding in zero cycles:
  - Write: cmd accept at edge 0, AW/W handshake at edge 1, B at edge 2, rsp_valid from cycle 3.
  - Read: same timing (AR at edge 1, R at edge 2, rsp_valid from cycle 3).
- Non-OKAY responses are passed through unmodified; no retry.
- Unexpected BVALID or RVALID outside WR_B/RD_R is ignored, since READY is low.

Optional Feature:
- Macro: AXI_LITE_WSTRB_EN.
- Defined:
  - Adds input cmd_wstrb[DATA_WIDTH/8] and output WSTRB[DATA_WIDTH/8].
  - cmd_wstrb is captured with the command and held on WSTRB during WR; WSTRB resets to 0.
- Undefined: no strobe ports; the slave treats every write as full-word.

Decomposition:
- Package axi_lite_pkg holds:
  - Response codes: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum for the master FSM.
- No sub-module; the single FSM plus capture registers stays under 250 lines.

Test Plan:
- Write addr 0x10, data 0xCAFEBABE against axi_master_slave -> AW/W handshake seen with those values; rsp_valid, rsp_write=1, rsp_resp=00.
- Read addr 0x10 after the write -> ARADDR=0x10; rsp_rdata=0xCAFEBABE, rsp_resp=00, rsp_write=0.
- Stub slave with AWREADY at cycle 1 and WREADY at cycle 4 -> AWVALID drops after cycle 1, WVALID held until cycle 4, BREADY rises only after both.
- Stub returns RRESP=10 with RDATA=0xDEADBEEF -> rsp_resp=10, rsp_rdata=0xDEADBEEF.
- rsp_ready held low for 5 cycles, with cmd_valid high for a second command -> rsp stable, cmd_ready=0; the second command is accepted only the cycle after the rsp handshake.
- ARESET pulsed while in WR_B waiting for BVALID -> next cycle all VALID/READY=0, rsp_valid never asserts, cmd_ready=1.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and master FSM state encoding
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_RSP} state_e;
endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator; every output is a flop.
// Define AXI_LITE_WSTRB_EN to add cmd_wstrb/WSTRB byte strobes.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
`ifdef AXI_LITE_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic                  write_q, write_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
`ifdef AXI_LITE_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
  assign WSTRB = strb_q;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    write_d     = write_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
`ifdef AXI_LITE_WSTRB_EN
    strb_d      = strb_q;
`endif
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        write_d   = cmd_write;
        rdata_d   = '0;
        resp_d    = RESP_OKAY;
        awvalid_d = cmd_write;
        wvalid_d  = cmd_write;
        arvalid_d = !cmd_write;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
`ifdef AXI_LITE_WSTRB_EN
        strb_d    = cmd_wstrb;
`endif
        state_d   = cmd_write ? S_WR : S_RD_A;
      end
      // AW and W complete independently; B is only requested once both are done
      S_WR: begin
        if (awvalid_q && AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end
      S_WR_B: if (BVALID && bready_q) begin
        resp_d      = BRESP;
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_RD_A: if (arvalid_q && ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_RD_R;
      end
      S_RD_R: if (RVALID && rready_q) begin
        rdata_d     = RDATA;
        resp_d      = RRESP;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      write_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef AXI_LITE_WSTRB_EN
      strb_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      write_q     <= write_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef AXI_LITE_WSTRB_EN
      strb_q      <= strb_d;
`endif
    end
  end

  // one captured address serves both AW and AR since only one transaction is ever in flight
  assign cmd_ready = (state_q == S_IDLE);
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign AWVALID   = awvalid_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed bench with a latency-configurable AXI4-Lite slave model
module tb_axi_lite_master;
  logic        ACLK, ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
`ifdef AXI_LITE_WSTRB_EN
  logic [3:0]  cmd_wstrb, WSTRB;
`endif

  int          n_cmp = 0, n_err = 0;
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic        b_hold = 1'b0, rd_force = 1'b0;
  logic [31:0] force_val = 32'h0;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, r_data;
  logic [31:0] mem [0:255];

  axi_lite_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef AXI_LITE_WSTRB_EN
    .cmd_wstrb(cmd_wstrb), .WSTRB(WSTRB),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // slave: READY rises after lat cycles of VALID; B follows one cycle after AW+W, R one cycle after AR
  assign AWREADY = AWVALID && !aw_got && aw_cnt >= aw_lat;
  assign WREADY  = WVALID && !w_got && w_cnt >= w_lat;
  assign ARREADY = ARVALID && ar_cnt >= ar_lat;
  assign BVALID  = b_pend && !b_hold;
  assign BRESP   = bresp_cfg;
  assign RVALID  = r_pend;
  assign RDATA   = r_data;
  assign RRESP   = rresp_cfg;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_data <= 32'h0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
      if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_a <= AWADDR; end
      if (WVALID && WREADY) begin w_got <= 1'b1; w_d <= WDATA; end
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY))) begin
        mem[(AWVALID && AWREADY) ? AWADDR[7:0] : aw_a[7:0]] <= (WVALID && WREADY) ? WDATA : w_d;
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
      end
      if (BVALID && BREADY) b_pend <= 1'b0;
      if (ARVALID && ARREADY) begin
        r_pend <= 1'b1;
        r_data <= rd_force ? force_val : mem[ARADDR[7:0]];
      end
      if (RVALID && RREADY) r_pend <= 1'b0;
    end
  end

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    n_cmp++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin n_err++; $display("FAIL reset_handshakes got %b exp 00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY}); end
    n_cmp++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b0) begin n_err++; $display("FAIL reset_rsp got %b exp 0000", {rsp_valid, rsp_write, rsp_resp}); end
    n_cmp++; if ({AWADDR, WDATA, ARADDR, rsp_rdata} !== 128'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", {AWADDR, WDATA, ARADDR, rsp_rdata}); end
  endtask

  task automatic test_write();
`ifdef AXI_LITE_WSTRB_EN
    cmd_wstrb = 4'b1010;
`endif
    send(1'b1, 32'h10, 32'hCAFEBABE);
    cmd_valid = 1'b0;
    n_cmp++; if ({cmd_ready, AWVALID, WVALID} !== 3'b011) begin n_err++; $display("FAIL wr_c1_valids got %b exp 011", {cmd_ready, AWVALID, WVALID}); end
    n_cmp++; if (AWADDR !== 32'h10) begin n_err++; $display("FAIL wr_awaddr got %h exp 00000010", AWADDR); end
    n_cmp++; if (WDATA !== 32'hCAFEBABE) begin n_err++; $display("FAIL wr_wdata got %h exp cafebabe", WDATA); end
`ifdef AXI_LITE_WSTRB_EN
    n_cmp++; if (WSTRB !== 4'b1010) begin n_err++; $display("FAIL wr_wstrb got %b exp 1010", WSTRB); end
`endif
    @(negedge ACLK);
    n_cmp++; if ({AWVALID, WVALID, BREADY, rsp_valid} !== 4'b0010) begin n_err++; $display("FAIL wr_c2 got %b exp 0010", {AWVALID, WVALID, BREADY, rsp_valid}); end
    @(negedge ACLK);
    n_cmp++; if ({rsp_valid, rsp_write, BREADY} !== 3'b110) begin n_err++; $display("FAIL wr_c3_rsp got %b exp 110", {rsp_valid, rsp_write, BREADY}); end
    n_cmp++; if ({rsp_resp, rsp_rdata} !== 34'h0) begin n_err++; $display("FAIL wr_c3_data got %h exp 0", {rsp_resp, rsp_rdata}); end
    n_cmp++; if (mem[8'h10] !== 32'hCAFEBABE) begin n_err++; $display("FAIL wr_slave_mem got %h exp cafebabe", mem[8'h10]); end
    finish_rsp();
    n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL wr_done got %b exp 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_read();
    send(1'b0, 32'h10, 32'h0);
    cmd_valid = 1'b0;
    n_cmp++; if ({ARVALID, AWVALID, WVALID} !== 3'b100) begin n_err++; $display("FAIL rd_c1 got %b exp 100", {ARVALID, AWVALID, WVALID}); end
    n_cmp++; if (ARADDR !== 32'h10) begin n_err++; $display("FAIL rd_araddr got %h exp 00000010", ARADDR); end
    @(negedge ACLK);
    n_cmp++; if ({ARVALID, RREADY} !== 2'b01) begin n_err++; $display("FAIL rd_c2 got %b exp 01", {ARVALID, RREADY}); end
    @(negedge ACLK);
    n_cmp++; if ({rsp_valid, rsp_write, rsp_resp, RREADY} !== 5'b10000) begin n_err++; $display("FAIL rd_c3 got %b exp 10000", {rsp_valid, rsp_write, rsp_resp, RREADY}); end
    n_cmp++; if (rsp_rdata !== 32'hCAFEBABE) begin n_err++; $display("FAIL rd_rdata got %h exp cafebabe", rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_wr_skew();
    w_lat = 3;
    send(1'b1, 32'h18, 32'h0BADF00D);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      logic [2:0] exp;
      exp = {c == 1, c <= 4, c == 5};
      n_cmp++; if ({AWVALID, WVALID, BREADY} !== exp) begin n_err++; $display("FAIL skew_c%0d got %b exp %b", c, {AWVALID, WVALID, BREADY}, exp); end
      @(negedge ACLK);
    end
    n_cmp++; if ({rsp_valid, rsp_write} !== 2'b11) begin n_err++; $display("FAIL skew_rsp got %b exp 11", {rsp_valid, rsp_write}); end
    n_cmp++; if (mem[8'h18] !== 32'h0BADF00D) begin n_err++; $display("FAIL skew_mem got %h exp 0badf00d", mem[8'h18]); end
    finish_rsp();
    w_lat = 0;
  endtask

  task automatic test_rd_err();
    ar_lat = 2; rd_force = 1'b1; force_val = 32'hDEADBEEF; rresp_cfg = 2'b10;
    send(1'b0, 32'h40, 32'h0);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      logic [1:0] exp;
      exp = {c <= 3, c == 4};
      n_cmp++; if ({ARVALID, RREADY} !== exp) begin n_err++; $display("FAIL rderr_c%0d got %b exp %b", c, {ARVALID, RREADY}, exp); end
      @(negedge ACLK);
    end
    n_cmp++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1010) begin n_err++; $display("FAIL rderr_rsp got %b exp 1010", {rsp_valid, rsp_write, rsp_resp}); end
    n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rderr_rdata got %h exp deadbeef", rsp_rdata); end
    finish_rsp();
    ar_lat = 0; rd_force = 1'b0; rresp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back();
    bresp_cfg = 2'b11;
    send(1'b1, 32'h20, 32'h12345678);
    cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0;
    repeat (2) @(negedge ACLK);
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({rsp_valid, rsp_write, rsp_resp, cmd_ready, ARVALID} !== 6'b111100) begin n_err++; $display("FAIL hold_k%0d got %b exp 111100", k, {rsp_valid, rsp_write, rsp_resp, cmd_ready, ARVALID}); end
      n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL hold_rdata_k%0d got %h exp 0", k, rsp_rdata); end
      if (k == 4) rsp_ready = 1'b1;
      @(negedge ACLK);
    end
    rsp_ready = 1'b0;
    bresp_cfg = 2'b00;
    n_cmp++; if ({rsp_valid, cmd_ready, ARVALID} !== 3'b010) begin n_err++; $display("FAIL b2b_idle got %b exp 010", {rsp_valid, cmd_ready, ARVALID}); end
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n_cmp++; if ({cmd_ready, ARVALID} !== 2'b01 || ARADDR !== 32'h20) begin n_err++; $display("FAIL b2b_accept got %b/%h exp 01/00000020", {cmd_ready, ARVALID}, ARADDR); end
    repeat (2) @(negedge ACLK);
    n_cmp++; if ({rsp_valid, rsp_write, rsp_resp} !== 4'b1000 || rsp_rdata !== 32'h12345678) begin n_err++; $display("FAIL b2b_read got %b/%h exp 1000/12345678", {rsp_valid, rsp_write, rsp_resp}, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    b_hold = 1'b1;
    send(1'b1, 32'h30, 32'hA5A5A5A5);
    cmd_valid = 1'b0;
    repeat (2) @(negedge ACLK);
    n_cmp++; if ({BREADY, rsp_valid, cmd_ready} !== 3'b100) begin n_err++; $display("FAIL mid_wr_b got %b exp 100", {BREADY, rsp_valid, cmd_ready}); end
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0; b_hold = 1'b0;
    n_cmp++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin n_err++; $display("FAIL mid_handshakes got %b exp 00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY}); end
    n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL mid_rsp got %b exp 01", {rsp_valid, cmd_ready}); end
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_quiet_c%0d got %b exp 0", c, rsp_valid); end
    end
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
`ifdef AXI_LITE_WSTRB_EN
    cmd_wstrb = 4'h0;
`endif
    test_reset();
    test_write();
    test_read();
    test_wr_skew();
    test_rd_err();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
